// File: rtl/mux3to8_de.sv
// rtl/mux3to8_de.sv - registered 3-to-8 decoder with enable, optional polarity and hold
// Optional feature: define MUX3TO8_DE_CHANGE_CNT_EN to add the 8-bit chg_cnt output.
module mux3to8_de #(
  parameter int OUT_ACTIVE_LOW  = 0,
  parameter int HOLD_ON_DISABLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       A,
  input  logic       B,
  input  logic       C,
`ifdef MUX3TO8_DE_CHANGE_CNT_EN
  output logic [7:0] chg_cnt,
`endif
  output logic [7:0] O,
  output logic       valid
);

  localparam logic [7:0] INACTIVE = (OUT_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [2:0] sel;
  logic [7:0] onehot;
  logic [7:0] next_o;

  assign sel    = {A, B, C};
  assign onehot = 8'd1 << sel;

  // XOR with the inactive pattern applies the output polarity in one step
  always_comb begin
    next_o = O;
    if (en) begin
      next_o = onehot ^ INACTIVE;
    end else if (HOLD_ON_DISABLE == 0) begin
      next_o = INACTIVE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O     <= INACTIVE;
      valid <= 1'b0;
    end else begin
      O     <= next_o;
      valid <= en;
    end
  end

`ifdef MUX3TO8_DE_CHANGE_CNT_EN
  // Counts edges where the registered output actually changes; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt <= 8'd0;
    end else if (next_o != O) begin
      chg_cnt <= chg_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux3to8_de.sv
// tb/tb_mux3to8_de.sv - self-checking bench for mux3to8_de across all four parameter combinations
// Instance g uses OUT_ACTIVE_LOW = g%2, HOLD_ON_DISABLE = g/2.
module tb_mux3to8_de;

  logic       clk;
  logic       rst;
  logic       en;
  logic       A, B, C;
  logic [7:0] o_w [4];
  logic [3:0] valid_w;
`ifdef MUX3TO8_DE_CHANGE_CNT_EN
  logic [7:0] chg_w [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mux3to8_de #(
      .OUT_ACTIVE_LOW (g % 2),
      .HOLD_ON_DISABLE(g / 2)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .A      (A),
      .B      (B),
      .C      (C),
`ifdef MUX3TO8_DE_CHANGE_CNT_EN
      .chg_cnt(chg_w[g]),
`endif
      .O      (o_w[g]),
      .valid  (valid_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: the decoded position held as an active-high byte per instance
  logic [7:0] m_ah  [4];
  logic       m_v;
  logic [7:0] m_cnt [4];

  function automatic logic [7:0] polar(int i, logic [7:0] ah);
    return (i % 2 == 1) ? ~ah : ah;
  endfunction

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ah[i]  = 8'h00;
      m_cnt[i] = 8'h00;
    end
    m_v = 1'b0;
  endtask

  task automatic model_edge(logic e, int s);
    logic [7:0] nxt;
    for (int i = 0; i < 4; i++) begin
      if (e) nxt = 8'(1 << s);
      else if (i / 2 == 1) nxt = m_ah[i];
      else nxt = 8'h00;
      if (nxt != m_ah[i]) m_cnt[i] = m_cnt[i] + 8'd1;
      m_ah[i] = nxt;
    end
    m_v = e;
  endtask

  task automatic check_model(string tag);
    for (int i = 0; i < 4; i++) begin
      chk8($sformatf("%s O[inst%0d]", tag, i), o_w[i], polar(i, m_ah[i]));
      chk1($sformatf("%s valid[inst%0d]", tag, i), valid_w[i], m_v);
`ifdef MUX3TO8_DE_CHANGE_CNT_EN
      chk8($sformatf("%s chg_cnt[inst%0d]", tag, i), chg_w[i], m_cnt[i]);
`endif
    end
  endtask

  // Call between a falling and the next rising edge; returns at the following falling edge
  task automatic step(logic e, int s);
    en = e;
    {A, B, C} = 3'(s);
    @(posedge clk);
    model_edge(e, s);
    @(negedge clk);
  endtask

  // Reset pulse placed entirely between two clock edges
  task automatic do_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk8($sformatf("%s rst O[inst%0d]", tag, i), o_w[i], (i % 2 == 1) ? 8'hFF : 8'h00);
      chk1($sformatf("%s rst valid[inst%0d]", tag, i), valid_w[i], 1'b0);
`ifdef MUX3TO8_DE_CHANGE_CNT_EN
      chk8($sformatf("%s rst chg_cnt[inst%0d]", tag, i), chg_w[i], 8'h00);
`endif
    end
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       en;
    int         s;
    logic [7:0] o0, o1, o2, o3;
    logic       v;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    {A, B, C} = 3'b000;
    model_reset();

    tbl = '{
      '{1'b1, 0, 8'h01, 8'hFE, 8'h01, 8'hFE, 1'b1},
      '{1'b1, 1, 8'h02, 8'hFD, 8'h02, 8'hFD, 1'b1},
      '{1'b1, 2, 8'h04, 8'hFB, 8'h04, 8'hFB, 1'b1},
      '{1'b1, 3, 8'h08, 8'hF7, 8'h08, 8'hF7, 1'b1},
      '{1'b1, 4, 8'h10, 8'hEF, 8'h10, 8'hEF, 1'b1},
      '{1'b1, 5, 8'h20, 8'hDF, 8'h20, 8'hDF, 1'b1},
      '{1'b1, 6, 8'h40, 8'hBF, 8'h40, 8'hBF, 1'b1},
      '{1'b1, 7, 8'h80, 8'h7F, 8'h80, 8'h7F, 1'b1},
      '{1'b1, 5, 8'h20, 8'hDF, 8'h20, 8'hDF, 1'b1},
      '{1'b1, 3, 8'h08, 8'hF7, 8'h08, 8'hF7, 1'b1},
      '{1'b0, 3, 8'h00, 8'hFF, 8'h08, 8'hF7, 1'b0},
      '{1'b0, 6, 8'h00, 8'hFF, 8'h08, 8'hF7, 1'b0},
      '{1'b1, 6, 8'h40, 8'hBF, 8'h40, 8'hBF, 1'b1}
    };

    #1;
    for (int i = 0; i < 4; i++)
      chk8($sformatf("power-on O[inst%0d]", i), o_w[i], (i % 2 == 1) ? 8'hFF : 8'h00);
    do_reset("init");

    for (int k = 0; k < 13; k++) begin
      step(tbl[k].en, tbl[k].s);
      chk8($sformatf("tbl%0d O[inst0]", k), o_w[0], tbl[k].o0);
      chk8($sformatf("tbl%0d O[inst1]", k), o_w[1], tbl[k].o1);
      chk8($sformatf("tbl%0d O[inst2]", k), o_w[2], tbl[k].o2);
      chk8($sformatf("tbl%0d O[inst3]", k), o_w[3], tbl[k].o3);
      chk1($sformatf("tbl%0d valid", k), valid_w[0], tbl[k].v);
      check_model($sformatf("tbl%0d", k));
    end

    // Reset mid-operation discards the 0x80 decode; next decode lands one edge after release
    step(1'b1, 7);
    chk8("pre-rst O[inst0]", o_w[0], 8'h80);
    do_reset("mid");
    step(1'b1, 2);
    chk8("post-rst O[inst0]", o_w[0], 8'h04);
    chk8("post-rst O[inst1]", o_w[1], 8'hFB);
    chk1("post-rst valid", valid_w[0], 1'b1);
    check_model("post-rst");

    // Full sweep then a repeated code: exactly eight output changes
    do_reset("cnt");
    for (int s = 0; s < 8; s++) step(1'b1, s);
    for (int r = 0; r < 3; r++) step(1'b1, 7);
    check_model("sweep-repeat");
`ifdef MUX3TO8_DE_CHANGE_CNT_EN
    for (int i = 0; i < 4; i++)
      chk8($sformatf("sweep-repeat chg_cnt[inst%0d]", i), chg_w[i], 8'd8);
`endif

    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, int'($urandom % 8));
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux3to8_de.md
MUX3TO8_DE -- requirements
Module: mux3to8_de

Interface
REQ-001 SHALL provide parameter OUT_ACTIVE_LOW, default 0; 1 = all O bits inverted (active bit 0, inactive bits 1).
REQ-002 SHALL provide parameter HOLD_ON_DISABLE, default 0; 1 = O holds its last value while en=0, 0 = O goes to the all-inactive pattern.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, decode enable sampled on clk rising edge.
REQ-007 SHALL have port A, input, 1, select bit 2 (MSB).
REQ-008 SHALL have port B, input, 1, select bit 1.
REQ-009 SHALL have port C, input, 1, select bit 0 (LSB).
REQ-010 SHALL have port O, output, 8, registered one-hot decoded output.
REQ-011 SHALL have port valid, output, 1, high while O holds a decode captured with en=1 on the previous edge.

Function
REQ-012 SHALL form select index S = {A,B,C}, range 0..7.
REQ-013 SHALL, on a rising clk edge with en=1, load O with only bit O[S] active and all other bits inactive.
REQ-014 SHALL have a latency of exactly one clock from sampled A/B/C/en to updated O/valid; there is no combinational path from inputs to outputs.
REQ-015 SHALL set valid=1 on an edge with en=1 and valid=0 on an edge with en=0.
REQ-016 SHALL, on an edge with en=0, load O with all-inactive (8'h00, or 8'hFF when OUT_ACTIVE_LOW=1) when HOLD_ON_DISABLE=0, and keep O unchanged when HOLD_ON_DISABLE=1.
REQ-017 SHALL, with OUT_ACTIVE_LOW=1, output the bitwise inverse of the active-high pattern; valid is unaffected by polarity.
REQ-018 SHALL never present more than one active O bit in any cycle.
REQ-019 SHALL update on back-to-back edges with en=1 and differing S, with no idle cycle required between decodes.
REQ-020 SHALL treat X/Z on A/B/C as don't-care; behaviour is defined only for 0/1 inputs.

Reset
REQ-021 SHALL, while rst=1, immediately (without a clock) drive O to all-inactive (8'h00, or 8'hFF when active low) and valid=0.
REQ-022 SHALL, on rst asserted mid-operation, discard the current decode; the first new decode appears one edge after rst deasserts with en=1.
REQ-023 SHALL reset the optional change counter to 0 under the same conditions.

Configuration
REQ-024 SHALL provide macro MUX3TO8_DE_CHANGE_CNT_EN; when defined, output chg_cnt (8 bits) increments on each edge where the new registered O differs from the old O, wraps 255->0, and resets to 0.
REQ-025 SHALL, when MUX3TO8_DE_CHANGE_CNT_EN is undefined, omit the chg_cnt port and counter logic entirely, with all other behaviour identical.

Verification
REQ-026 SHALL cover: default parameters, en=1, sweep {A,B,C}=000..111 one per clock -> O = 01,02,04,08,10,20,40,80 each one clock later, valid=1.
REQ-027 SHALL cover: OUT_ACTIVE_LOW=1, {A,B,C}=101, en=1 -> O=8'hDF next clock.
REQ-028 SHALL cover: HOLD_ON_DISABLE=0, decode 011, then en=0 -> O=8'h00, valid=0 next clock; HOLD_ON_DISABLE=1 same stimulus -> O stays 8'h08, valid=0.
REQ-029 SHALL cover: rst pulsed between clock edges while O=8'h80 -> O=8'h00 and valid=0 immediately; after release with en=1 and S=010 -> O=8'h04 one edge later.
REQ-030 SHALL cover: with MUX3TO8_DE_CHANGE_CNT_EN, the 8-code sweep followed by repeating 111 for 3 clocks -> chg_cnt=8.
